// File: rtl/fft_stage_scheduler.sv
// Address/control sequencer for an in-place radix-2 DIT FFT with ping-pong banks.
// Issues butterfly read/twiddle addresses per stage and replays them as write addresses after the BFU latency.
module fft_stage_scheduler #(
    parameter int ADDR_WIDTH  = 5,
    parameter int BFU_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            stage,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] addr_A_read,
    output logic [ADDR_WIDTH-1:0] addr_B_read,
    output logic [ADDR_WIDTH-2:0] addr_Twiddle,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] addr_A_write,
    output logic [ADDR_WIDTH-1:0] addr_B_write,
    output logic                  roW
);

    localparam int              BFW        = ADDR_WIDTH - 1;
    localparam logic [BFW-1:0]  BF_LAST    = '1;
    localparam logic [2:0]      STAGE_LAST = 3'(ADDR_WIDTH - 1);
    localparam logic [1:0]      DRAIN_LAST = 2'(BFU_LATENCY - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [BFW-1:0]        bf_q, bf_d;
    logic [2:0]            stage_q, stage_d;
    logic                  row_q, row_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
    logic [BFW-1:0]        tw_q;

    logic [ADDR_WIDTH-1:0] span, bf_ext, a_calc, b_calc;
    logic [BFW-1:0]        mask_bf, tw_calc;

    always_comb begin
        state_d    = state_q;
        bf_d       = bf_q;
        stage_d    = stage_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    bf_d       = '0;
                    stage_d    = '0;
                    row_d      = 1'b0;
                    rd_valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bf_q == BF_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    bf_d       = bf_q + BFW'(1);
                    rd_valid_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        state_d    = S_RUN;
                        stage_d    = stage_q + 3'd1;
                        row_d      = ~row_q;
                        bf_d       = '0;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are computed for the next butterfly so the registered outputs line up with rd_valid.
    always_comb begin
        span    = ADDR_WIDTH'(1) << stage_d;
        mask_bf = span[BFW-1:0] - BFW'(1);
        bf_ext  = {1'b0, bf_d};
        a_calc  = ((bf_ext >> stage_d) << (stage_d + 3'd1)) | {1'b0, bf_d & mask_bf};
        b_calc  = a_calc + span;
        tw_calc = (bf_d & mask_bf) << (STAGE_LAST - stage_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bf_q       <= '0;
            stage_q    <= '0;
            row_q      <= 1'b0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_q       <= '0;
        end else begin
            state_q    <= state_d;
            bf_q       <= bf_d;
            stage_q    <= stage_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            if (rd_valid_d) begin
                addr_a_q <= a_calc;
                addr_b_q <= b_calc;
                tw_q     <= tw_calc;
            end
        end
    end

    // Write side: plain delay line of the read strobe and addresses, so held read addresses stay held here too.
    logic                  pipe_v_q [BFU_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_a_q [BFU_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_b_q [BFU_LATENCY];

    generate
        for (genvar gi = 0; gi < BFU_LATENCY; gi++) begin : g_pipe
            logic                  src_v;
            logic [ADDR_WIDTH-1:0] src_a, src_b;
            if (gi == 0) begin : g_head
                assign src_v = rd_valid_q;
                assign src_a = addr_a_q;
                assign src_b = addr_b_q;
            end else begin : g_tail
                assign src_v = pipe_v_q[gi-1];
                assign src_a = pipe_a_q[gi-1];
                assign src_b = pipe_b_q[gi-1];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe_v_q[gi] <= 1'b0;
                    pipe_a_q[gi] <= '0;
                    pipe_b_q[gi] <= '0;
                end else begin
                    pipe_v_q[gi] <= src_v;
                    pipe_a_q[gi] <= src_a;
                    pipe_b_q[gi] <= src_b;
                end
            end
        end
    endgenerate

    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_FIN);
    assign stage        = stage_q;
    assign roW          = row_q;
    assign rd_valid     = rd_valid_q;
    assign addr_A_read  = addr_a_q;
    assign addr_B_read  = addr_b_q;
    assign addr_Twiddle = tw_q;
    assign wr_en        = pipe_v_q[BFU_LATENCY-1];
    assign addr_A_write = pipe_a_q[BFU_LATENCY-1];
    assign addr_B_write = pipe_b_q[BFU_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: four instances with BFU_LATENCY 1..4 share stimulus.
// Index D (latency 2) carries the cycle-exact reference-trace checks.
module tb_fft_stage_scheduler;

    localparam int D = 1;

    logic clk = 1'b0;
    logic reset;
    logic start;

    logic       busy_v [4];
    logic       done_v [4];
    logic [2:0] stage_v [4];
    logic       rd_valid_v [4];
    logic [4:0] a_r_v [4];
    logic [4:0] b_r_v [4];
    logic [3:0] tw_v [4];
    logic       wr_en_v [4];
    logic [4:0] a_w_v [4];
    logic [4:0] b_w_v [4];
    logic       row_v [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            fft_stage_scheduler #(.ADDR_WIDTH(5), .BFU_LATENCY(gi + 1)) u_dut (
                .clk          (clk),
                .reset        (reset),
                .start        (start),
                .busy         (busy_v[gi]),
                .done         (done_v[gi]),
                .stage        (stage_v[gi]),
                .rd_valid     (rd_valid_v[gi]),
                .addr_A_read  (a_r_v[gi]),
                .addr_B_read  (b_r_v[gi]),
                .addr_Twiddle (tw_v[gi]),
                .wr_en        (wr_en_v[gi]),
                .addr_A_write (a_w_v[gi]),
                .addr_B_write (b_w_v[gi]),
                .roW          (row_v[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] outs(input int i);
        return {busy_v[i], done_v[i], rd_valid_v[i], wr_en_v[i], row_v[i], stage_v[i],
                a_r_v[i], b_r_v[i], tw_v[i], a_w_v[i], b_w_v[i]};
    endfunction

    function automatic int exp_a(input int s, input int bf);
        return ((bf >> s) << (s + 1)) | (bf & ((1 << s) - 1));
    endfunction

    function automatic int exp_tw(input int s, input int bf);
        return ((bf & ((1 << s) - 1)) << (4 - s)) & 15;
    endfunction

    // Start accepted at the posedge that ends cycle 0; returns at the sample point of cycle 1.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs(i) !== 32'h0)
                $display("FAIL reset_outputs inst %0d: got %h expected 00000000", i, outs(i));
            if (outs(i) !== 32'h0) errors++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_pass(input string name);
        int wr_count = 0;
        launch();
        for (int k = 1; k <= 95; k++) begin
            bit in_pass = (k <= 90);
            int s = (k - 1) / 18;
            int o = (k - 1) % 18;
            int rbf = (o < 16) ? o : 15;
            logic [3:0] ctrl_exp = {in_pass, (k == 91), in_pass && (o < 16), in_pass && (o >= 2)};
            logic [3:0] ctrl_got = {busy_v[D], done_v[D], rd_valid_v[D], wr_en_v[D]};
            checks++;
            if (ctrl_got !== ctrl_exp) begin
                $display("FAIL %s_ctrl cycle %0d: busy/done/rd/wr got %b expected %b", name, k, ctrl_got, ctrl_exp);
                errors++;
            end
            if (wr_en_v[D] === 1'b1) wr_count++;
            if (in_pass) begin
                checks++;
                if ({stage_v[D], row_v[D]} !== {3'(s), 1'(s % 2)}) begin
                    $display("FAIL %s_stage_row cycle %0d: got %0d/%b expected %0d/%0d", name, k, stage_v[D], row_v[D], s, s % 2);
                    errors++;
                end
                checks++;
                if (int'(a_r_v[D]) !== exp_a(s, rbf) || int'(b_r_v[D]) !== exp_a(s, rbf) + (1 << s)
                    || int'(tw_v[D]) !== exp_tw(s, rbf)) begin
                    $display("FAIL %s_read_addr cycle %0d: got A=%0d B=%0d tw=%0d expected A=%0d B=%0d tw=%0d", name, k,
                             a_r_v[D], b_r_v[D], tw_v[D], exp_a(s, rbf), exp_a(s, rbf) + (1 << s), exp_tw(s, rbf));
                    errors++;
                end
            end
            if (in_pass && (o >= 2 || s > 0)) begin
                int ws = (o >= 2) ? s : s - 1;
                int wbf = (o >= 2) ? o - 2 : 15;
                checks++;
                if (int'(a_w_v[D]) !== exp_a(ws, wbf) || int'(b_w_v[D]) !== exp_a(ws, wbf) + (1 << ws)) begin
                    $display("FAIL %s_write_addr cycle %0d: got A=%0d B=%0d expected A=%0d B=%0d", name, k,
                             a_w_v[D], b_w_v[D], exp_a(ws, wbf), exp_a(ws, wbf) + (1 << ws));
                    errors++;
                end
            end
            if (k == 1) begin
                checks++;
                if ({rd_valid_v[D], stage_v[D], a_r_v[D], b_r_v[D], tw_v[D]} !== {1'b1, 3'd0, 5'd0, 5'd1, 4'd0}) begin
                    $display("FAIL %s_first_read: got rd=%b st=%0d A=%0d B=%0d tw=%0d expected 1 0 0 1 0", name,
                             rd_valid_v[D], stage_v[D], a_r_v[D], b_r_v[D], tw_v[D]);
                    errors++;
                end
            end
            if (k == 3) begin
                checks++;
                if ({wr_en_v[D], a_w_v[D], b_w_v[D]} !== {1'b1, 5'd0, 5'd1}) begin
                    $display("FAIL %s_first_write: got wr=%b A=%0d B=%0d expected 1 0 1", name, wr_en_v[D], a_w_v[D], b_w_v[D]);
                    errors++;
                end
            end
            if (k == 6 || k == 42 || k == 88) begin
                logic [13:0] v_exp = (k == 6)  ? {5'd10, 5'd11, 4'd0} :
                                     (k == 42) ? {5'd9, 5'd13, 4'd4} : {5'd15, 5'd31, 4'd15};
                checks++;
                if ({a_r_v[D], b_r_v[D], tw_v[D]} !== v_exp) begin
                    $display("FAIL %s_vector cycle %0d: got A=%0d B=%0d tw=%0d expected A=%0d B=%0d tw=%0d", name, k,
                             a_r_v[D], b_r_v[D], tw_v[D], v_exp[13:9], v_exp[8:4], v_exp[3:0]);
                    errors++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (wr_count !== 80) begin
            $display("FAIL %s_wr_count: got %0d expected 80", name, wr_count);
            errors++;
        end
    endtask

    task automatic test_latency_sweep();
        bit rd_seen [4][5][32];
        int wr_cnt [4][5][32];
        int done_cyc [4];
        for (int li = 0; li < 4; li++) begin
            done_cyc[li] = -1;
            for (int s = 0; s < 5; s++)
                for (int a = 0; a < 32; a++) begin
                    rd_seen[li][s][a] = 1'b0;
                    wr_cnt[li][s][a] = 0;
                end
        end
        launch();
        for (int k = 1; k <= 110; k++) begin
            for (int li = 0; li < 4; li++) begin
                int p = 17 + li;
                int s = (k - 1) / p;
                if (wr_en_v[li] === 1'b1) begin
                    checks++;
                    if (k > 5 * p || !rd_seen[li][s][a_w_v[li]] || !rd_seen[li][s][b_w_v[li]]) begin
                        $display("FAIL lat%0d_write_order cycle %0d: write A=%0d B=%0d not preceded by its read in stage", li + 1, k, a_w_v[li], b_w_v[li]);
                        errors++;
                    end else begin
                        wr_cnt[li][s][a_w_v[li]]++;
                        wr_cnt[li][s][b_w_v[li]]++;
                    end
                end
                if (rd_valid_v[li] === 1'b1 && k <= 5 * p) begin
                    rd_seen[li][s][a_r_v[li]] = 1'b1;
                    rd_seen[li][s][b_r_v[li]] = 1'b1;
                end
                if (done_v[li] === 1'b1 && done_cyc[li] < 0) done_cyc[li] = k;
            end
            @(negedge clk);
        end
        for (int li = 0; li < 4; li++) begin
            checks++;
            if (done_cyc[li] !== 5 * (17 + li) + 1) begin
                $display("FAIL lat%0d_done_cycle: got %0d expected %0d", li + 1, done_cyc[li], 5 * (17 + li) + 1);
                errors++;
            end
            for (int s = 0; s < 5; s++)
                for (int a = 0; a < 32; a++) begin
                    checks++;
                    if (wr_cnt[li][s][a] !== 1) begin
                        $display("FAIL lat%0d_write_once stage %0d addr %0d: got %0d writes expected 1", li + 1, s, a, wr_cnt[li][s][a]);
                        errors++;
                    end
                end
        end
    endtask

    task automatic test_start_ignored();
        launch();
        for (int k = 1; k <= 120; k++) begin
            checks++;
            if ({busy_v[D], done_v[D]} !== {(k <= 90), (k == 91)}) begin
                $display("FAIL start_ignored cycle %0d: busy/done got %b%b expected %b%b", k, busy_v[D], done_v[D], (k <= 90), (k == 91));
                errors++;
            end
            start = (k == 5 || k == 17 || k == 18 || k == 50 || k == 90 || k == 91);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_start_held();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 185; k++) begin
            bit eb = (k <= 90) || (k >= 93 && k <= 182);
            bit ed = (k == 91) || (k == 183);
            checks++;
            if ({busy_v[D], done_v[D]} !== {eb, ed}) begin
                $display("FAIL start_held cycle %0d: busy/done got %b%b expected %b%b", k, busy_v[D], done_v[D], eb, ed);
                errors++;
            end
            if (k == 93) begin
                checks++;
                if ({rd_valid_v[D], stage_v[D], a_r_v[D], b_r_v[D]} !== {1'b1, 3'd0, 5'd0, 5'd1}) begin
                    $display("FAIL start_held_relaunch: got rd=%b st=%0d A=%0d B=%0d expected 1 0 0 1", rd_valid_v[D], stage_v[D], a_r_v[D], b_r_v[D]);
                    errors++;
                end
            end
            if (k == 182) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midpass();
        launch();
        repeat (39) @(negedge clk);
        checks++;
        if (busy_v[D] !== 1'b1) begin
            $display("FAIL midpass_busy cycle 40: got %b expected 1", busy_v[D]);
            errors++;
        end
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs(i) !== 32'h0) begin
                $display("FAIL midpass_reset inst %0d: got %h expected 00000000", i, outs(i));
                errors++;
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({busy_v[i], wr_en_v[i]} !== 2'b00) begin
                    $display("FAIL post_reset_quiet inst %0d cycle %0d: busy/wr got %b%b expected 00", i, k, busy_v[i], wr_en_v[i]);
                    errors++;
                end
            end
        end
        test_full_pass("restart");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_latency_sweep();
        test_full_pass("pass");
        test_start_ignored();
        test_start_held();
        test_reset_midpass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
